wb_uart_fifo: RTL

Parametrised Wishbone UART slave and next generation of the team's bus UART. It contains its own TX serializer and RX deserializer, so no external UART core is needed. It adds RX/TX FIFOs, a runtime baud divisor, a registered Wishbone ack, a status register with sticky error flags, and a maskable interrupt. It sits on the J1 CPU data bus in the I/O region selected by adr_i[15:12].

---
 rtl/wb_uart_fifo.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_fifo.sv
// Wishbone UART slave with its own TX serializer and RX deserializer, RX/TX
// FIFOs, runtime baud divisor, sticky error flags and a maskable level interrupt.

module wb_uart_fifo_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          push_ok
);
  logic [7:0]  mem [2**AW];
  logic [AW:0] wptr, rptr;
  logic        do_pop;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still accepted when a pop frees the slot.
  assign push_ok = push & (~count[AW] | do_pop);
  assign head    = mem[rptr[AW-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

module wb_uart_fifo #(
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter logic [3:0]  BASE        = 4'hF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic [15:0] dat_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [15:0] adr_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [15:0] dat_o,
  output logic        irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic        sel, wr, rd;
  logic [1:0]  reg_sel;
  logic [15:0] div;
  logic [2:0]  ie;
  logic        rx_overrun, frame_err, tx_overflow;
  logic [15:0] rdata, status;
  logic        unused_adr;

  logic               tx_push, tx_pop, tx_empty, tx_push_ok, tx_full, tx_empty_idle;
  logic [7:0]         tx_head;
  logic [FIFO_AW:0]   tx_count;
  logic               rx_push, rx_pop, rx_empty, rx_push_ok;
  logic [7:0]         rx_head;
  logic [FIFO_AW:0]   rx_count;

  state_t      tx_state;
  logic [15:0] tx_cnt, tx_bdiv;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick, tx_load;

  state_t                 rx_state;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s, rx_prev, rx_fall, rx_tick;
  logic [15:0]            rx_cnt, rx_half;
  logic [2:0]             rx_bit;
  logic [7:0]             rx_shift;

  assign unused_adr = ^adr_i[11:2];

  assign sel     = cyc_i & stb_i & (adr_i[15:12] == BASE) & ~ack_o;
  assign wr      = sel & we_i;
  assign rd      = sel & ~we_i;
  assign reg_sel = adr_i[1:0];

  assign tx_push = wr & (reg_sel == 2'd0);
  assign rx_pop  = rd & (reg_sel == 2'd0);

  wb_uart_fifo_buf #(.AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(dat_i[7:0]), .pop(tx_pop),
    .head(tx_head), .count(tx_count), .empty(tx_empty), .push_ok(tx_push_ok)
  );

  wb_uart_fifo_buf #(.AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_shift), .pop(rx_pop),
    .head(rx_head), .count(rx_count), .empty(rx_empty), .push_ok(rx_push_ok)
  );

  assign tx_full       = tx_count[FIFO_AW];
  assign tx_empty_idle = tx_empty & (tx_state == S_IDLE);
  assign status = {8'(rx_count), 2'b00, tx_overflow, frame_err, rx_overrun,
                   tx_empty_idle, tx_full, ~rx_empty};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = {8'h00, rx_empty ? 8'h00 : rx_head};
      2'd1: rdata = status;
      2'd2: rdata = div;
      2'd3: rdata = {13'b0, ie};
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_o       <= 1'b0;
      dat_o       <= '0;
      div         <= DEFAULT_DIV;
      ie          <= '0;
      irq_o       <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      ack_o <= sel;
      dat_o <= rd ? rdata : 16'h0000;
      if (wr && reg_sel == 2'd2) div <= dat_i;
      if (wr && reg_sel == 2'd3) ie  <= dat_i[2:0];
      if (wr && reg_sel == 2'd1) begin
        if (dat_i[3]) rx_overrun  <= 1'b0;
        if (dat_i[4]) frame_err   <= 1'b0;
        if (dat_i[5]) tx_overflow <= 1'b0;
      end
      // A new error in the same cycle as a clear wins.
      if (rx_push && !rx_push_ok) rx_overrun  <= 1'b1;
      if (rx_push && !rx_s)       frame_err   <= 1'b1;
      if (tx_push && !tx_push_ok) tx_overflow <= 1'b1;
      irq_o <= |(ie & {rx_overrun | frame_err | tx_overflow, tx_empty_idle, ~rx_empty});
    end
  end

  // TX: each state lasts tx_bdiv+1 clocks; the divisor is re-latched per bit.
  assign tx_tick = (tx_cnt == tx_bdiv);
  assign tx_load = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_tick));
  assign tx_pop  = tx_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bdiv  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_state <= S_START;
      tx       <= 1'b0;
      tx_shift <= tx_head;
      tx_cnt   <= '0;
      tx_bdiv  <= div;
    end else begin
      case (tx_state)
        S_START, S_DATA: begin
          if (tx_tick) begin
            tx_cnt  <= '0;
            tx_bdiv <= div;
            if (tx_state == S_DATA && tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              if (tx_state == S_DATA) tx_bit <= tx_bit + 3'd1;
              else                    tx_bit <= '0;
              tx_state <= S_DATA;
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_tick) tx_state <= S_IDLE;
          else         tx_cnt   <= tx_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // RX: rx_cnt counts down to the next sample point.
  assign rx_s    = rx_sync[SYNC_STAGES-1];
  assign rx_fall = rx_prev & ~rx_s;
  assign rx_tick = (rx_cnt == '0);
  assign rx_half = 16'(({1'b0, div} + 17'd1) >> 1);
  assign rx_push = (rx_state == S_STOP) & rx_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_bit <= '0;
            // With a one-clock bit the start bit is already sampled on detection.
            if (rx_half == '0) begin
              rx_state <= S_DATA;
              rx_cnt   <= div;
            end else begin
              rx_state <= S_START;
              rx_cnt   <= rx_half - 16'd1;
            end
          end
        end
        S_START: begin
          if (!rx_tick)  rx_cnt   <= rx_cnt - 16'd1;
          else if (rx_s) rx_state <= S_IDLE;
          else begin
            rx_state <= S_DATA;
            rx_cnt   <= div;
          end
        end
        S_DATA: begin
          if (!rx_tick) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= div;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end
        end
        S_STOP: begin
          if (!rx_tick) rx_cnt   <= rx_cnt - 16'd1;
          else          rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule
